// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, NOP encoding and the fetch FSM state type.
package cpu_pkg;
  localparam int          OPC_MSB   = 15;
  localparam int          OPC_LSB   = 12;
  localparam logic [3:0]  OPC_HLT   = 4'b1111;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_HLT;
  endfunction
endpackage

// File: rtl/ifid_pipe_reg.sv
// Pipeline register (instr / pc2 / valid) with load, hold and bubble controls.
// Bubble clears instr and valid but keeps pc2; bubble has priority over load.
module ifid_pipe_reg
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc2_in,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc2,
  output logic               valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc2   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= INSTR_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc2   <= pc2_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, RUN/HALTED FSM, IF/ID register; priority flush > stall_id > miss > normal.
// Optional saturating perf counters under `ifdef FETCH_PERF_CNT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall_id,
  input  logic               flush,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc2,
  output logic               ifid_valid,
  output logic               fetch_halted,
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_miss_cnt
);
  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            load;
  logic            bubble;
  logic            hlt_op;

  assign pc_inc       = pc + PC_W'(2);
  assign hlt_op       = is_hlt(imem_rdata[15:0]);
  assign imem_addr    = pc;
  assign imem_req     = (state == RUN);
  assign fetch_halted = (state == HALTED);

  always_comb begin
    load   = 1'b0;
    bubble = 1'b0;
    if (flush) begin
      bubble = 1'b1;
    end else if (stall_id) begin
      bubble = 1'b0;
    end else if (state == HALTED || !imem_valid) begin
      bubble = 1'b1;
    end else begin
      load = 1'b1;
    end
  end

  // HLT is still delivered to ID, but the PC stays on it until a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (flush) begin
      pc    <= br_target & ~PC_W'(1);
      state <= RUN;
    end else if (load) begin
      if (hlt_op) state <= HALTED;
      else        pc    <= pc_inc;
    end
  end

  ifid_pipe_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bubble   (bubble),
    .instr_in (imem_rdata),
    .pc2_in   (pc_inc),
    .instr    (ifid_instr),
    .pc2      (ifid_pc2),
    .valid    (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic miss_cycle;
  assign miss_cycle = (state == RUN) && !flush && !stall_id && !imem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_miss_cnt  <= '0;
    end else begin
      if (load && perf_fetch_cnt != 16'hFFFF)      perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (miss_cycle && perf_miss_cnt != 16'hFFFF) perf_miss_cnt  <= perf_miss_cnt + 16'd1;
    end
  end
`else
  assign perf_fetch_cnt = 16'h0000;
  assign perf_miss_cnt  = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a rule-level reference model.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall_id;
  logic        flush;
  logic [15:0] br_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic        fetch_halted;
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_miss_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_pc2, m_fc, m_mc;
  logic        m_valid, m_halt;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .stall_id       (stall_id),
    .flush          (flush),
    .br_target      (br_target),
    .ifid_instr     (ifid_instr),
    .ifid_pc2       (ifid_pc2),
    .ifid_valid     (ifid_valid),
    .fetch_halted   (fetch_halted),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0; m_fc = 16'h0000; m_mc = 16'h0000;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},   imem_addr,    m_pc);
    chk({tag, ".req"},    imem_req,     !m_halt);
    chk({tag, ".halted"}, fetch_halted, m_halt);
    chk({tag, ".valid"},  ifid_valid,   m_valid);
    chk({tag, ".instr"},  ifid_instr,   m_instr);
    if (m_valid) chk({tag, ".pc2"}, ifid_pc2, m_pc2);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".fcnt"}, perf_fetch_cnt, m_fc);
    chk({tag, ".mcnt"}, perf_miss_cnt,  m_mc);
`else
    chk({tag, ".fcnt"}, perf_fetch_cnt, 16'h0000);
    chk({tag, ".mcnt"}, perf_miss_cnt,  16'h0000);
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
  task automatic step(input string tag, input logic fl, input logic st, input logic v,
                      input logic [15:0] rd, input logic [15:0] bt);
    flush = fl; stall_id = st; imem_valid = v; imem_rdata = rd; br_target = bt;
    if (fl) begin
      m_pc = {bt[15:1], 1'b0};
      m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_halt) begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end else if (!v) begin
      m_instr = 16'h0000; m_valid = 1'b0;
      if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
    end else begin
      m_instr = rd; m_valid = 1'b1; m_pc2 = m_pc + 16'd2;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (rd[15:12] == 4'hF) m_halt = 1'b1;
      else                   m_pc   = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall_id = 1'b0; imem_valid = 1'b0;
    imem_rdata = 16'h0000; br_target = 16'h0000;
    model_reset();
    #3;
    check_all("reset");
    #9 rst_n = 1'b1;

    // sequential hits
    step("hit0", 0, 0, 1, 16'h1123, 0);
    step("hit1", 0, 0, 1, 16'h2456, 0);
    chk("hit1.pc2_abs", ifid_pc2, 16'h0004);
    step("hit2", 0, 0, 1, 16'h3789, 0);
    chk("hit2.instr_abs", ifid_instr, 16'h3789);
    chk("hit2.pc2_abs", ifid_pc2, 16'h0006);

    // miss at a fixed address, then delivery
    flush = 1'b1; br_target = 16'h0004;
    step("toward4", 1, 0, 0, 0, 16'h0004);
    for (int i = 0; i < 3; i++) step("miss", 0, 0, 0, 16'hABCD, 0);
    chk("miss.addr_abs", imem_addr, 16'h0004);
    step("miss_done", 0, 0, 1, 16'h4001, 0);

    // stall_id holds everything even on a hit
    step("stall0", 0, 1, 1, 16'h5002, 0);
    step("stall1", 0, 1, 1, 16'h5002, 0);
    chk("stall.instr_abs", ifid_instr, 16'h4001);
    step("release", 0, 0, 1, 16'h5002, 0);
    step("next", 0, 0, 1, 16'h5003, 0);

    // flush during miss and during stall
    step("fl_miss", 1, 0, 0, 16'h7777, 16'h0040);
    chk("fl_miss.addr_abs", imem_addr, 16'h0040);
    step("fl_hit", 0, 0, 1, 16'h1234, 0);
    step("fl_stall", 1, 1, 1, 16'h7777, 16'h0041);
    chk("fl_stall.valid_abs", ifid_valid, 1'b0);

    // HLT and resume via redirect
    step("to_a", 1, 0, 0, 0, 16'h000B);
    step("hlt", 0, 0, 1, 16'hF000, 0);
    chk("hlt.addr_abs", imem_addr, 16'h000A);
    chk("hlt.req_abs", imem_req, 1'b0);
    step("halted0", 0, 0, 1, 16'h1111, 0);
    step("halted1", 0, 1, 1, 16'h2222, 0);
    step("resume", 1, 0, 1, 16'h3333, 16'h0020);
    step("resume_hit", 0, 0, 1, 16'h1001, 0);

    // async reset mid-miss and mid-HALTED
    step("pre_miss", 0, 0, 0, 0, 0);
    async_reset("rst_miss");
    step("after_rst", 0, 0, 1, 16'hF123, 0);
    async_reset("rst_halt");

    // PC wrap
    step("to_fffe", 1, 0, 0, 0, 16'hFFFE);
    step("wrap", 0, 0, 1, 16'h0ABC, 0);
    chk("wrap.addr_abs", imem_addr, 16'h0000);
    chk("wrap.pc2_abs", ifid_pc2, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic fl, st, v;
      logic [15:0] rd, bt;
      fl = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 15);
      v  = ($urandom_range(0, 99) < 70);
      rd = 16'($urandom);
      bt = 16'($urandom);
      step("rand", fl, st, v, rd, bt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
